// File: rtl/alu_pkg.sv
// Shared ALU op codes, MIPS opcode/funct constants and issue FSM types.
// Used by alu_issue_ctrl (optional ALU_ISSUE_FAST_EN) and alu_issue_decode.
package alu_pkg;

  typedef enum logic [5:0] {
    ALU_ADD  = 6'd0,
    ALU_ADDU = 6'd1,
    ALU_SUB  = 6'd2,
    ALU_SUBU = 6'd3,
    ALU_AND  = 6'd4,
    ALU_OR   = 6'd5,
    ALU_XOR  = 6'd6,
    ALU_NOR  = 6'd7,
    ALU_SLT  = 6'd8,
    ALU_SLTU = 6'd9,
    ALU_SLL  = 6'd10,
    ALU_SRL  = 6'd11,
    ALU_SRA  = 6'd12,
    ALU_SLLV = 6'd13,
    ALU_SRLV = 6'd14,
    ALU_SRAV = 6'd15,
    ALU_LUI  = 6'd16
  } alu_op_e;

  localparam logic [5:0] OPC_R     = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    S_IDLE, S_DECODE, S_EXEC, S_WB
  } state_e;

  typedef enum logic [1:0] {
    B_RT, B_SEXT, B_ZEXT
  } b_sel_e;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational MIPS ALU-op decoder: func, operand selects, dest,
// overflow-checked op flag and illegal flag.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0] inst,
  output logic [5:0]  func,
  output logic        a_shamt,
  output logic [1:0]  b_sel,
  output logic [4:0]  dest,
  output logic        is_ovf_op,
  output logic        illegal
);

  logic [5:0] op;
  logic [5:0] fn;
  alu_op_e    f;
  b_sel_e     bs;
  logic       unused_fields;

  assign op = inst[31:26];
  assign fn = inst[5:0];
  assign unused_fields = ^{inst[25:21], inst[10:6]};

  always_comb begin
    f         = ALU_ADD;
    a_shamt   = 1'b0;
    bs        = B_RT;
    dest      = inst[15:11];
    is_ovf_op = 1'b0;
    illegal   = 1'b0;
    unique case (1'b1)
      (op == OPC_R): begin
        case (fn)
          FN_ADD:  begin f = ALU_ADD; is_ovf_op = 1'b1; end
          FN_ADDU: f = ALU_ADDU;
          FN_SUB:  begin f = ALU_SUB; is_ovf_op = 1'b1; end
          FN_SUBU: f = ALU_SUBU;
          FN_AND:  f = ALU_AND;
          FN_OR:   f = ALU_OR;
          FN_XOR:  f = ALU_XOR;
          FN_NOR:  f = ALU_NOR;
          FN_SLT:  f = ALU_SLT;
          FN_SLTU: f = ALU_SLTU;
          FN_SLL:  begin f = ALU_SLL; a_shamt = 1'b1; end
          FN_SRL:  begin f = ALU_SRL; a_shamt = 1'b1; end
          FN_SRA:  begin f = ALU_SRA; a_shamt = 1'b1; end
          FN_SLLV: f = ALU_SLLV;
          FN_SRLV: f = ALU_SRLV;
          FN_SRAV: f = ALU_SRAV;
          default: illegal = 1'b1;
        endcase
      end
      default: begin
        dest = inst[20:16];
        case (op)
          OPC_ADDI: begin
            f = ALU_ADD; bs = B_SEXT; is_ovf_op = 1'b1;
          end
          OPC_ADDIU: begin f = ALU_ADDU; bs = B_SEXT; end
          OPC_SLTI:  begin f = ALU_SLT;  bs = B_SEXT; end
          OPC_SLTIU: begin f = ALU_SLTU; bs = B_SEXT; end
          OPC_ANDI:  begin f = ALU_AND;  bs = B_ZEXT; end
          OPC_ORI:   begin f = ALU_OR;   bs = B_ZEXT; end
          OPC_XORI:  begin f = ALU_XOR;  bs = B_ZEXT; end
          OPC_LUI:   begin f = ALU_LUI;  bs = B_ZEXT; end
          default:   illegal = 1'b1;
        endcase
      end
    endcase
  end

  assign func  = f;
  assign b_sel = bs;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue/control unit for the shared ALU.
// ALU_ISSUE_FAST_EN: skip DECODE, load operands on accept.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FUNC_W = 6,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [31:0]       inst,
  output logic [REG_AW-1:0] rs_addr,
  output logic [REG_AW-1:0] rt_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [FUNC_W-1:0] alu_func,
  input  logic [DATA_W-1:0] alu_res,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              ov_exc,
  output logic              illegal
);

  localparam int MSB = DATA_W - 1;

  state_e            state;
  logic [31:0]       inst_q;
  logic [31:0]       dec_inst;
  logic [REG_AW-1:0] dest_q;
  logic              ovf_q;

  logic [5:0]        d_func;
  logic              d_a_shamt;
  logic [1:0]        d_b_sel;
  logic [4:0]        d_dest;
  logic              d_ovf_op;
  logic              d_illegal;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [15:0]       imm;
  logic              sign_ok;
  logic              ovf;

`ifdef ALU_ISSUE_FAST_EN
  logic unused_q;
  assign unused_q = ^{inst_q[31:26], inst_q[15:0]};
  assign dec_inst = inst;
  assign rs_addr  = (state == S_IDLE) ?
                    REG_AW'(inst[25:21]) : REG_AW'(inst_q[25:21]);
  assign rt_addr  = (state == S_IDLE) ?
                    REG_AW'(inst[20:16]) : REG_AW'(inst_q[20:16]);
`else
  assign dec_inst = inst_q;
  assign rs_addr  = REG_AW'(inst_q[25:21]);
  assign rt_addr  = REG_AW'(inst_q[20:16]);
`endif

  alu_issue_decode u_dec (
    .inst      (dec_inst),
    .func      (d_func),
    .a_shamt   (d_a_shamt),
    .b_sel     (d_b_sel),
    .dest      (d_dest),
    .is_ovf_op (d_ovf_op),
    .illegal   (d_illegal)
  );

  assign imm = dec_inst[15:0];

  always_comb begin
    op_a = d_a_shamt ? DATA_W'(dec_inst[10:6]) : rs_data;
    case (d_b_sel)
      B_SEXT:  op_b = {{(DATA_W-16){imm[15]}}, imm};
      B_ZEXT:  op_b = {{(DATA_W-16){1'b0}}, imm};
      default: op_b = rt_data;
    endcase
  end

  // Signed overflow from operand/result signs; ALU flags are not used.
  assign sign_ok = (alu_func == FUNC_W'(ALU_SUB)) ?
                   (alu_a[MSB] != alu_b[MSB]) :
                   (alu_a[MSB] == alu_b[MSB]);
  assign ovf = ovf_q && sign_ok && (alu_res[MSB] != alu_a[MSB]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      inst_ready <= 1'b1;
      inst_q     <= '0;
      dest_q     <= '0;
      ovf_q      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_func   <= '0;
      wb_valid   <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      ov_exc     <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      ov_exc  <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (inst_valid) begin
            inst_q     <= inst;
            inst_ready <= 1'b0;
`ifdef ALU_ISSUE_FAST_EN
            if (d_illegal) begin
              illegal    <= 1'b1;
              inst_ready <= 1'b1;
            end else begin
              alu_a    <= op_a;
              alu_b    <= op_b;
              alu_func <= FUNC_W'(d_func);
              dest_q   <= REG_AW'(d_dest);
              ovf_q    <= d_ovf_op;
              state    <= S_EXEC;
            end
`else
            state <= S_DECODE;
`endif
          end
        end
        S_DECODE: begin
          if (d_illegal) begin
            illegal    <= 1'b1;
            inst_ready <= 1'b1;
            state      <= S_IDLE;
          end else begin
            alu_a    <= op_a;
            alu_b    <= op_b;
            alu_func <= FUNC_W'(d_func);
            dest_q   <= REG_AW'(d_dest);
            ovf_q    <= d_ovf_op;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (ovf) begin
            ov_exc     <= 1'b1;
            inst_ready <= 1'b1;
            state      <= S_IDLE;
          end else if (dest_q == '0) begin
            inst_ready <= 1'b1;
            state      <= S_IDLE;
          end else begin
            wb_valid <= 1'b1;
            wb_addr  <= dest_q;
            wb_data  <= alu_res;
            state    <= S_WB;
          end
        end
        S_WB: begin
          if (wb_ready) begin
            wb_valid   <= 1'b0;
            inst_ready <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed cases plus
// randomized instructions against a MIPS-level reference model.
module tb_alu_issue_ctrl;

`ifdef ALU_ISSUE_FAST_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif

  localparam int K_WB  = 0;
  localparam int K_OVF = 1;
  localparam int K_ILL = 2;
  localparam int K_D0  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [5:0]  alu_func;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ov_exc, illegal;

  logic [31:0] regs [32];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_res(alu_res),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .ov_exc(ov_exc), .illegal(illegal)
  );

  always_comb begin
    rs_data = regs[rs_addr];
    rt_data = regs[rt_addr];
  end

  // Shared ALU seen by the unit
  always_comb begin
    alu_res = 32'h0;
    case (alu_func)
      6'd0, 6'd1:   alu_res = alu_a + alu_b;
      6'd2, 6'd3:   alu_res = alu_a - alu_b;
      6'd4:         alu_res = alu_a & alu_b;
      6'd5:         alu_res = alu_a | alu_b;
      6'd6:         alu_res = alu_a ^ alu_b;
      6'd7:         alu_res = ~(alu_a | alu_b);
      6'd8:  alu_res = {31'h0, $signed(alu_a) < $signed(alu_b)};
      6'd9:  alu_res = {31'h0, alu_a < alu_b};
      6'd10, 6'd13: alu_res = alu_b << alu_a[4:0];
      6'd11, 6'd14: alu_res = alu_b >> alu_a[4:0];
      6'd12, 6'd15: alu_res = $signed(alu_b) >>> alu_a[4:0];
      6'd16:        alu_res = alu_b << 16;
      default:      alu_res = 32'h0;
    endcase
  end

  function automatic logic [31:0] rt_i(input int s, t, d, sh,
                                       input logic [5:0] fn);
    rt_i = {6'h0, 5'(s), 5'(t), 5'(d), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] it_i(input logic [5:0] op,
                                       input int s, t,
                                       input logic [15:0] imm);
    it_i = {op, 5'(s), 5'(t), imm};
  endfunction

  // MIPS-level reference: outcome kind, dest and written value
  function automatic void model(input logic [31:0] i,
                                input logic [31:0] a, b,
                                output int kind,
                                output logic [4:0] d,
                                output logic [31:0] v);
    logic [5:0]  op, fn;
    logic [4:0]  sh;
    logic [31:0] se, ze;
    logic [32:0] w;
    logic        ov;
    op = i[31:26]; fn = i[5:0]; sh = i[10:6];
    se = {{16{i[15]}}, i[15:0]};
    ze = {16'h0, i[15:0]};
    kind = K_WB; v = 32'h0; ov = 1'b0;
    if (op == 6'h0) begin
      d = i[15:11];
      case (fn)
        6'h20: begin
          w = {a[31], a} + {b[31], b}; v = w[31:0]; ov = w[32] != w[31];
        end
        6'h21: v = a + b;
        6'h22: begin
          w = {a[31], a} - {b[31], b}; v = w[31:0]; ov = w[32] != w[31];
        end
        6'h23: v = a - b;
        6'h24: v = a & b;
        6'h25: v = a | b;
        6'h26: v = a ^ b;
        6'h27: v = ~(a | b);
        6'h2A: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h2B: v = (a < b) ? 32'd1 : 32'd0;
        6'h00: v = b << sh;
        6'h02: v = b >> sh;
        6'h03: v = $signed(b) >>> sh;
        6'h04: v = b << a[4:0];
        6'h06: v = b >> a[4:0];
        6'h07: v = $signed(b) >>> a[4:0];
        default: kind = K_ILL;
      endcase
    end else begin
      d = i[20:16];
      case (op)
        6'h08: begin
          w = {a[31], a} + {se[31], se}; v = w[31:0]; ov = w[32] != w[31];
        end
        6'h09: v = a + se;
        6'h0A: v = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
        6'h0B: v = (a < se) ? 32'd1 : 32'd0;
        6'h0C: v = a & ze;
        6'h0D: v = a | ze;
        6'h0E: v = a ^ ze;
        6'h0F: v = {i[15:0], 16'h0};
        default: kind = K_ILL;
      endcase
    end
    if (kind == K_WB && ov) kind = K_OVF;
    else if (kind == K_WB && d == 5'd0) kind = K_D0;
  endfunction

  // Issue one instruction, follow it to completion, compare with model
  task automatic run_one(input logic [31:0] i, input int hold,
                         output logic [31:0] ga, gb,
                         output logic [5:0] gf,
                         output logic [31:0] gd,
                         output logic [4:0] gad);
    int kind;
    logic [4:0] ed;
    logic [31:0] ev;
    int wb_c, ov_c, il_c, done_c, held;
    model(i, regs[i[25:21]], regs[i[20:16]], kind, ed, ev);
    wb_c = -1; ov_c = -1; il_c = -1; done_c = -1; held = 0;
    ga = 'x; gb = 'x; gf = 'x; gd = '0; gad = '0;
    @(negedge clk);
    inst = i; inst_valid = 1'b1; wb_ready = 1'b0;
    total++;
    if (inst_ready !== 1'b1)
      $display("FAIL ready_idle inst=%h got=%b want=1", i, inst_ready);
    if (inst_ready !== 1'b1) bad++;
    @(negedge clk);
    inst_valid = 1'b0; inst = $urandom;
    for (int c = 1; c <= 12 && done_c < 0; c++) begin
      if (c > 1) @(negedge clk);
      if (c == LAT - 1) begin ga = alu_a; gb = alu_b; gf = alu_func; end
      if (ov_exc) ov_c = c;
      if (illegal) il_c = c;
      if (inst_ready) done_c = c;
      else if (wb_valid) begin
        if (wb_c < 0) begin
          wb_c = c; gd = wb_data; gad = wb_addr;
        end else begin
          total++;
          if (wb_data !== gd || wb_addr !== gad) begin
            bad++;
            $display("FAIL wb_hold c=%0d got=%h/%0d want=%h/%0d",
                     c, wb_data, wb_addr, gd, gad);
          end
        end
        wb_ready = (held >= hold);
        held++;
      end
    end
    wb_ready = 1'b0;
    total++;
    if (done_c < 0) begin
      bad++;
      $display("FAIL timeout inst=%h got=no_ready want=ready", i);
    end
    case (kind)
      K_WB: begin
        total++;
        if (wb_c != LAT) begin
          bad++;
          $display("FAIL wb_cycle inst=%h got=%0d want=%0d", i, wb_c, LAT);
        end
        total++;
        if (gd !== ev || gad !== ed) begin
          bad++;
          $display("FAIL wb_value inst=%h got=%h/%0d want=%h/%0d",
                   i, gd, gad, ev, ed);
        end
        total++;
        if (ov_c >= 0 || il_c >= 0) begin
          bad++;
          $display("FAIL wb_pulse inst=%h got=ov%0d/il%0d want=none",
                   i, ov_c, il_c);
        end
      end
      K_OVF: begin
        total++;
        if (ov_c != LAT || wb_c >= 0 || done_c != LAT) begin
          bad++;
          $display("FAIL ovf inst=%h got=ov%0d/wb%0d/rdy%0d want=ov%0d",
                   i, ov_c, wb_c, done_c, LAT);
        end
      end
      K_ILL: begin
        total++;
        if (il_c != LAT - 1 || wb_c >= 0 || done_c != LAT - 1) begin
          bad++;
          $display("FAIL illegal inst=%h got=il%0d/wb%0d/rdy%0d want=il%0d",
                   i, il_c, wb_c, done_c, LAT - 1);
        end
      end
      default: begin
        total++;
        if (wb_c >= 0 || ov_c >= 0 || il_c >= 0 || done_c != LAT) begin
          bad++;
          $display("FAIL dest0 inst=%h got=wb%0d/ov%0d/il%0d/rdy%0d want=rdy%0d",
                   i, wb_c, ov_c, il_c, done_c, LAT);
        end
      end
    endcase
  endtask

  task automatic test_reset();
    total++;
    if (inst_ready !== 1'b1) begin
      bad++; $display("FAIL rst_ready got=%b want=1", inst_ready);
    end
    total++;
    if ({wb_valid, ov_exc, illegal} !== 3'b000) begin
      bad++;
      $display("FAIL rst_flags got=%b want=000", {wb_valid, ov_exc, illegal});
    end
    total++;
    if (alu_a !== 0 || alu_b !== 0 || alu_func !== 0) begin
      bad++;
      $display("FAIL rst_alu got=%h/%h/%0d want=0", alu_a, alu_b, alu_func);
    end
    total++;
    if (wb_data !== 0 || wb_addr !== 0) begin
      bad++; $display("FAIL rst_wb got=%h/%0d want=0", wb_data, wb_addr);
    end
  endtask

  task automatic test_addu();
    logic [31:0] ga, gb, gd;
    logic [5:0] gf;
    logic [4:0] gad;
    regs[1] = 32'd5; regs[2] = 32'd7;
    run_one(rt_i(1, 2, 3, 0, 6'h21), 0, ga, gb, gf, gd, gad);
    total++;
    if (gf !== 6'd1 || ga !== 32'd5 || gb !== 32'd7) begin
      bad++;
      $display("FAIL addu_alu got=%h/%h/%0d want=5/7/1", ga, gb, gf);
    end
    total++;
    if (gd !== 32'd12 || gad !== 5'd3) begin
      bad++; $display("FAIL addu_wb got=%h/%0d want=c/3", gd, gad);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] ga, gb, gd;
    logic [5:0] gf;
    logic [4:0] gad;
    regs[1] = 32'h7FFF_FFFF; regs[2] = 32'h1;
    run_one(rt_i(1, 2, 3, 0, 6'h20), 0, ga, gb, gf, gd, gad);
    regs[1] = 32'h8000_0000;
    run_one(rt_i(1, 2, 6, 0, 6'h22), 0, ga, gb, gf, gd, gad);
    run_one(it_i(6'h08, 1, 7, 16'hFFFF), 0, ga, gb, gf, gd, gad);
    regs[1] = 32'h7FFF_FFFF;
    run_one(it_i(6'h08, 1, 7, 16'h0001), 0, ga, gb, gf, gd, gad);
  endtask

  task automatic test_shift_lui();
    logic [31:0] ga, gb, gd;
    logic [5:0] gf;
    logic [4:0] gad;
    regs[2] = 32'h1;
    run_one(rt_i(0, 2, 4, 4, 6'h00), 0, ga, gb, gf, gd, gad);
    total++;
    if (ga !== 32'd4 || gb !== 32'd1 || gf !== 6'd10 || gd !== 32'h10) begin
      bad++;
      $display("FAIL sll got=%h/%h/%0d/%h want=4/1/10/10", ga, gb, gf, gd);
    end
    run_one(it_i(6'h0F, 0, 5, 16'h1234), 0, ga, gb, gf, gd, gad);
    total++;
    if (gf !== 6'd16 || gd !== 32'h1234_0000 || gad !== 5'd5) begin
      bad++;
      $display("FAIL lui got=%0d/%h/%0d want=16/12340000/5", gf, gd, gad);
    end
  endtask

  task automatic test_stall();
    logic [31:0] ga, gb, gd;
    logic [5:0] gf;
    logic [4:0] gad;
    regs[8] = 32'hDEAD_0000; regs[9] = 32'h0000_BEEF;
    run_one(rt_i(8, 9, 10, 0, 6'h25), 3, ga, gb, gf, gd, gad);
    run_one(it_i(6'h0E, 9, 11, 16'hF0F0), 2, ga, gb, gf, gd, gad);
  endtask

  task automatic test_illegal_dest0();
    logic [31:0] ga, gb, gd;
    logic [5:0] gf;
    logic [4:0] gad;
    run_one({6'h3F, 26'h0}, 0, ga, gb, gf, gd, gad);
    run_one(rt_i(1, 2, 3, 0, 6'h01), 0, ga, gb, gf, gd, gad);
    run_one(rt_i(1, 2, 0, 0, 6'h21), 0, ga, gb, gf, gd, gad);
  endtask

  task automatic test_reset_exec();
    logic [31:0] ga, gb, gd;
    logic [5:0] gf;
    logic [4:0] gad;
    regs[1] = 32'd5; regs[2] = 32'd7;
    @(negedge clk);
    inst = rt_i(1, 2, 3, 0, 6'h21); inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    repeat (LAT - 2) @(negedge clk);
    total++;
    if (alu_func !== 6'd1) begin
      bad++; $display("FAIL pre_rst_func got=%0d want=1", alu_func);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (alu_a !== 0 || alu_b !== 0 || alu_func !== 0 ||
        wb_valid !== 0 || wb_data !== 0 || ov_exc !== 0 || illegal !== 0) begin
      bad++;
      $display("FAIL rst_exec got=%h/%h/%0d/%b/%h want=0",
               alu_a, alu_b, alu_func, wb_valid, wb_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (inst_ready !== 1'b1 || wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_release got=%b/%b want=1/0", inst_ready, wb_valid);
    end
    run_one(it_i(6'h09, 0, 2, 16'hFFFF), 0, ga, gb, gf, gd, gad);
    total++;
    if (gd !== 32'hFFFF_FFFF || gad !== 5'd2) begin
      bad++; $display("FAIL addiu_m1 got=%h/%0d want=ffffffff/2", gd, gad);
    end
  endtask

  task automatic test_random();
    logic [31:0] ga, gb, gd;
    logic [5:0] gf;
    logic [4:0] gad;
    logic [5:0] fns [16];
    logic [31:0] specials [4];
    logic [31:0] i;
    int sel;
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    specials = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1};
    for (int n = 0; n < 80; n++) begin
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 3) == 0)
          regs[$urandom_range(1, 31)] = specials[$urandom_range(0, 3)];
        else
          regs[$urandom_range(1, 31)] = $urandom;
      end
      i = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 5) begin
        i[31:26] = 6'h0;
        i[5:0] = (sel == 0) ? 6'($urandom) : fns[$urandom_range(0, 15)];
      end else if (sel < 9) begin
        i[31:26] = 6'($urandom_range(8, 15));
      end
      run_one(i, $urandom_range(0, 2), ga, gb, gf, gd, gad);
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) regs[r] = (r == 0) ? 32'h0 : $urandom;
    rst_n = 1'b0; inst_valid = 1'b0; inst = 32'h0; wb_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_addu();
    test_overflow();
    test_shift_lui();
    test_stall();
    test_illegal_dest0();
    test_reset_exec();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
